q_search_scheduler: RTL and testbench

Q_SEARCH_SCHEDULER -- requirements
Module: q_search_scheduler

---
 rtl/q_search_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_q_search_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/q_search_scheduler.sv
// q_search_scheduler: walks NUM_Q candidate q indices through the datapath and keeps the minimum metric.
// Optional per-candidate watchdog is compiled in with QS_TIMEOUT_EN.
module q_search_scheduler #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int NUM_Q       = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 start_new_q,
    output logic [3:0]           q_index,
    input  logic                 q_done,
    input  logic                 metric_valid,
    input  logic [ACC_WIDTH-1:0] metric,
    output logic [3:0]           best_q,
    output logic [ACC_WIDTH-1:0] best_metric,
    output logic                 best_valid,
    output logic                 search_done,
    output logic                 busy,
    output logic                 timeout_err
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_ISSUE | start_new_q pulse for q_index
    // S_WAIT  | collecting metrics until q_done (or watchdog expiry)
    // S_NEXT  | advance q_index or finish
    // S_DONE  | search_done pulse
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

    if (NUM_Q < 2 || NUM_Q > 16 || TIMEOUT_CYC < 1 || N < 1 || Q < 0 || Q > N) begin : g_bad_params
        $error("q_search_scheduler: illegal parameter value");
    end

    localparam logic [3:0] LAST_Q = 4'(NUM_Q - 1);

    state_t               state_q, state_d;
    logic                 start_new_q_q, start_new_q_d;
    logic [3:0]           q_index_q, q_index_d;
    logic [3:0]           best_q_q, best_q_d;
    logic [ACC_WIDTH-1:0] best_metric_q, best_metric_d;
    logic                 best_valid_q, best_valid_d;
    logic                 search_done_q, search_done_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 close_cand;

`ifdef QS_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_expire;
    logic            timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        start_new_q_d = 1'b0;
        search_done_d = 1'b0;
        q_index_d     = q_index_q;
        best_q_d      = best_q_q;
        best_metric_d = best_metric_q;
        best_valid_d  = best_valid_q;
`ifdef QS_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        wd_expire     = (state_q == S_WAIT) && !q_done && (wd_cnt_q == '0);
        accept        = (state_q == S_WAIT) && metric_valid && !wd_expire &&
                        (!best_valid_q || (metric < best_metric_q));
        close_cand    = (state_q == S_WAIT) && (q_done || wd_expire);
`else
        accept        = (state_q == S_WAIT) && metric_valid &&
                        (!best_valid_q || (metric < best_metric_q));
        close_cand    = (state_q == S_WAIT) && q_done;
`endif

        // abort outranks start, q_done and metrics in the same cycle
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d       = S_ISSUE;
                        start_new_q_d = 1'b1;
                        q_index_d     = '0;
                        best_valid_d  = 1'b0;
                        best_metric_d = '1;
`ifdef QS_TIMEOUT_EN
                        timeout_err_d = 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
`ifdef QS_TIMEOUT_EN
                    wd_cnt_d = WD_LOAD;
`endif
                end
                S_WAIT: begin
                    if (accept) begin
                        best_metric_d = metric;
                        best_q_d      = q_index_q;
                        best_valid_d  = 1'b1;
                    end
                    if (close_cand) begin
                        state_d = S_NEXT;
                    end
`ifdef QS_TIMEOUT_EN
                    if (wd_expire) begin
                        timeout_err_d = 1'b1;
                    end else if (!q_done) begin
                        wd_cnt_d = wd_cnt_q - 1'b1;
                    end
`endif
                end
                S_NEXT: begin
                    if (q_index_q == LAST_Q) begin
                        state_d       = S_DONE;
                        search_done_d = 1'b1;
                    end else begin
                        q_index_d     = q_index_q + 4'd1;
                        state_d       = S_ISSUE;
                        start_new_q_d = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_new_q_q <= 1'b0;
            q_index_q     <= '0;
            best_q_q      <= '0;
            best_metric_q <= '1;
            best_valid_q  <= 1'b0;
            search_done_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef QS_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            start_new_q_q <= start_new_q_d;
            q_index_q     <= q_index_d;
            best_q_q      <= best_q_d;
            best_metric_q <= best_metric_d;
            best_valid_q  <= best_valid_d;
            search_done_q <= search_done_d;
            busy_q        <= busy_d;
`ifdef QS_TIMEOUT_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign start_new_q = start_new_q_q;
    assign q_index     = q_index_q;
    assign best_q      = best_q_q;
    assign best_metric = best_metric_q;
    assign best_valid  = best_valid_q;
    assign search_done = search_done_q;
    assign busy        = busy_q;
`ifdef QS_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_q_search_scheduler.sv
// Directed bench for q_search_scheduler: table of full searches plus abort, reset and watchdog sequences.
module tb_q_search_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, abort, q_done, metric_valid;
    logic [31:0] metric;
    logic        start_new_q, best_valid, search_done, busy, timeout_err;
    logic [3:0]  q_index, best_q;
    logic [31:0] best_metric;

    int checks   = 0;
    int failures = 0;

    q_search_scheduler #(.N(32), .Q(16), .ACC_WIDTH(32), .NUM_Q(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_new_q(start_new_q), .q_index(q_index), .q_done(q_done),
        .metric_valid(metric_valid), .metric(metric), .best_q(best_q),
        .best_metric(best_metric), .best_valid(best_valid), .search_done(search_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] vmask;
        logic [15:0] cmask;
        logic [15:0] xmask;
        logic [31:0] m  [16];
        logic [31:0] mx [16];
        logic        exp_valid;
        logic [3:0]  exp_q;
        logic [31:0] exp_metric;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Entered in the start_new_q cycle of candidate k; leaves in the cycle two after q_done.
    task automatic do_cand(input int k, input bit has_m, input logic [31:0] m, input bit coin,
                           input bit has_x, input logic [31:0] mx, input bit last);
        chk("issue_pulse", start_new_q, 1);
        chk("q_index", q_index, k);
        tick();
        chk("issue_one_cycle", start_new_q, 0);
        if (has_m && !coin) begin
            metric_valid = 1; metric = m; tick(); metric_valid = 0;
        end else begin
            tick();
        end
        if (has_x) begin
            metric_valid = 1; metric = mx; tick(); metric_valid = 0;
        end
        if (has_m && coin) begin
            metric_valid = 1; metric = m;
        end
        q_done = 1; tick(); q_done = 0; metric_valid = 0;
        chk("next_quiet", {start_new_q, search_done}, 0);
        tick();
        chk("busy_mid", busy, 1);
        if (last) chk("search_done_lat", search_done, 1);
    endtask

    task automatic run_row(input int r);
        start = 1; tick(); start = 0;
        for (int k = 0; k < 16; k++)
            do_cand(k, vecs[r].vmask[k], vecs[r].m[k], vecs[r].cmask[k],
                    vecs[r].xmask[k], vecs[r].mx[k], k == 15);
        tick();
        chk({vecs[r].name, "_done_one"}, search_done, 0);
        chk({vecs[r].name, "_idle"}, busy, 0);
        chk({vecs[r].name, "_valid"}, best_valid, vecs[r].exp_valid);
        chk({vecs[r].name, "_metric"}, best_metric, vecs[r].exp_metric);
        if (vecs[r].exp_valid) chk({vecs[r].name, "_best_q"}, best_q, vecs[r].exp_q);
    endtask

    initial begin
        for (int r = 0; r < 6; r++) begin
            vecs[r].vmask = '1; vecs[r].cmask = '0; vecs[r].xmask = '0;
            for (int k = 0; k < 16; k++) begin
                vecs[r].m[k] = '0; vecs[r].mx[k] = '0;
            end
        end
        vecs[0].name = "descend";
        for (int k = 0; k < 16; k++) vecs[0].m[k] = 32'(100 - 5 * k);
        vecs[0].exp_valid = 1; vecs[0].exp_q = 4'd15; vecs[0].exp_metric = 32'd25;
        vecs[1].name = "tie";
        for (int k = 0; k < 16; k++) vecs[1].m[k] = 32'd50;
        vecs[1].m[3] = 32'd10; vecs[1].m[9] = 32'd10;
        vecs[1].exp_valid = 1; vecs[1].exp_q = 4'd3; vecs[1].exp_metric = 32'd10;
        vecs[2].name = "skip0";
        for (int k = 0; k < 16; k++) vecs[2].m[k] = 32'd7;
        vecs[2].vmask[0] = 1'b0;
        vecs[2].exp_valid = 1; vecs[2].exp_q = 4'd1; vecs[2].exp_metric = 32'd7;
        vecs[3] = vecs[2];
        vecs[3].name = "coincident";
        vecs[3].cmask[4] = 1'b1; vecs[3].m[4] = 32'd2;
        vecs[3].exp_q = 4'd4; vecs[3].exp_metric = 32'd2;
        vecs[4].name = "nometric";
        vecs[4].vmask = '0;
        vecs[4].exp_valid = 0; vecs[4].exp_q = 4'd0; vecs[4].exp_metric = '1;
        vecs[5].name = "multi";
        for (int k = 0; k < 16; k++) vecs[5].m[k] = 32'd40;
        vecs[5].m[5] = 32'd60; vecs[5].xmask[5] = 1'b1; vecs[5].mx[5] = 32'd30;
        vecs[5].xmask[7] = 1'b1; vecs[5].mx[7] = 32'd30;
        vecs[5].exp_valid = 1; vecs[5].exp_q = 4'd5; vecs[5].exp_metric = 32'd30;

        rst = 1; start = 0; abort = 0; q_done = 0; metric_valid = 0; metric = '0;
        tick(); tick();
        chk("rst_outs", {start_new_q, q_index, best_q, best_valid, search_done, busy, timeout_err}, 0);
        chk("rst_metric", best_metric, 32'hFFFF_FFFF);
        rst = 0; tick();

        metric_valid = 1; metric = 32'd0; q_done = 1; tick();
        metric_valid = 0; q_done = 0;
        chk("idle_ignore_valid", best_valid, 0);
        chk("idle_ignore_metric", best_metric, 32'hFFFF_FFFF);
        chk("idle_ignore_busy", {busy, start_new_q}, 0);

        for (int r = 0; r < 6; r++) run_row(r);

        // abort during candidate 6, with a stray start and a coincident q_done
        start = 1; tick(); start = 0;
        for (int k = 0; k < 6; k++) do_cand(k, 1, 32'(20 + k), 0, 0, 0, 0);
        chk("abort_q6_issue", {start_new_q, q_index}, {1'b1, 4'd6});
        tick();
        start = 1; tick(); start = 0;
        chk("start_ignored", {start_new_q, q_index, busy}, {1'b0, 4'd6, 1'b1});
        abort = 1; q_done = 1; metric_valid = 1; metric = 32'd0; tick();
        abort = 0; q_done = 0; metric_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_hold", {best_valid, best_q, best_metric}, {1'b1, 4'd0, 32'd20});
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", {search_done, start_new_q}, 0);
            tick();
        end
        start = 1; tick(); start = 0;
        chk("restart_q0", {start_new_q, q_index, busy}, {1'b1, 4'd0, 1'b1});
        abort = 1; start = 1; tick(); abort = 0; start = 0;
        chk("abort_over_start", {busy, start_new_q}, 0);

        // reset mid-search outranks start and abort
        start = 1; tick(); start = 0; tick(); tick();
        rst = 1; start = 1; abort = 1; tick();
        rst = 0; start = 0; abort = 0;
        chk("rst_mid", {start_new_q, q_index, best_q, best_valid, search_done, busy}, 0);
        chk("rst_mid_metric", best_metric, 32'hFFFF_FFFF);
        tick();
        chk("rst_mid_quiet", {search_done, busy}, 0);

`ifdef QS_TIMEOUT_EN
        start = 1; tick(); start = 0;
        do_cand(0, 1, 32'd50, 0, 0, 0, 0);
        do_cand(1, 1, 32'd50, 0, 0, 0, 0);
        chk("wd_issue", {start_new_q, q_index}, {1'b1, 4'd2});
        repeat (8) tick();
        chk("wd_still_wait", {start_new_q, timeout_err}, 0);
        metric_valid = 1; metric = 32'd5; tick(); metric_valid = 0;
        chk("wd_err", timeout_err, 1);
        chk("wd_next", start_new_q, 0);
        tick();
        for (int k = 3; k < 16; k++) do_cand(k, 1, (k == 7) ? 32'd20 : 32'd60, 0, 0, 0, k == 15);
        tick();
        chk("wd_best", {best_valid, best_q, best_metric}, {1'b1, 4'd7, 32'd20});
        chk("wd_sticky", {timeout_err, busy}, {1'b1, 1'b0});
        start = 1; tick(); start = 0;
        chk("wd_clear", timeout_err, 0);
        abort = 1; tick(); abort = 0;
`else
        chk("timeout_tied", timeout_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
